// File: rtl/mult_slave_pkg.sv
// Shared types and constants for the matrix multiply/add slave controller.
// Watchdog support in mult_slave_ctrl is enabled by defining MULT_SLAVE_TMO_EN.
package mult_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] ADDR_OPA      = 4'd0;
  localparam logic [3:0] ADDR_OPB      = 4'd1;
  localparam logic [3:0] ADDR_INT_EN   = 4'd2;
  localparam logic [3:0] ADDR_CMD      = 4'd3;
  localparam logic [3:0] ADDR_STATUS   = 4'd4;
  localparam logic [3:0] ADDR_INT_PEND = 4'd5;
  localparam logic [3:0] ADDR_RADDR    = 4'd6;
  localparam logic [3:0] ADDR_RESULT   = 4'd7;

  localparam int unsigned CMD_START_BIT = 0;
  localparam int unsigned CMD_CLEAR_BIT = 1;

  localparam int unsigned STAT_OVF_BIT  = 2;
  localparam int unsigned STAT_SERR_BIT = 3;
  localparam int unsigned STAT_TMO_BIT  = 4;
  localparam int unsigned STAT_CNTA_LSB = 8;
  localparam int unsigned STAT_CNTB_LSB = 16;

  localparam int unsigned INT_DONE_BIT = 0;
  localparam int unsigned INT_ERR_BIT  = 1;

endpackage

// File: rtl/mult_slave_cnt.sv
// Saturating operand counter: accepts pushes only while allowed and below DEPTH,
// otherwise flags a sticky overflow. Cleared synchronously by clear.
module mult_slave_cnt #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             allow,
  output logic             accept,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  assign accept = push && allow && (cnt != CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + CNT_W'(1);
    end else if (push) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/mult_slave_ctrl.sv
// Bus-slave controller for the multiply/add engine: operand pushes, command FSM,
// status/interrupt registers. Define MULT_SLAVE_TMO_EN to add the MULT/ADD watchdog.
module mult_slave_ctrl
  import mult_slave_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               S_sel,
  input  logic               S_wr,
  input  logic [3:0]         S_address,
  input  logic [DATA_W-1:0]  S_din,
  output logic [DATA_W-1:0]  S_dout,
  output logic [DATA_W-1:0]  multiplicand,
  output logic               multiplicand_we,
  output logic [DATA_W-1:0]  multiplier,
  output logic               multiplier_we,
  output logic               multi_opstart,
  input  logic               multi_opdone,
  output logic               adder_opstart,
  input  logic               adder_opdone,
  output logic               multi_opclear,
  output logic [RADDR_W-1:0] rAddr,
  input  logic [DATA_W-1:0]  result,
  output logic               m_interrupt
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_t state_q, state_d;

  logic wr, rd, clear_cmd, start_cmd, push_a, push_b, acc_a, acc_b;
  logic ovf_a, ovf_b, full, tmo_hit;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic multi_go, adder_go, done_set, serr_set, tmo_set;
  logic start_err_q, timeout_q;
  logic [1:0] int_en_q, int_pend_q, w1c_mask, set_mask;
  logic [DATA_W-1:0] status, rd_data;

  assign wr = S_sel & S_wr;
  assign rd = S_sel & ~S_wr;

  // CLEAR masks START when both bits arrive in the same command write
  assign clear_cmd = wr && (S_address == ADDR_CMD) && S_din[CMD_CLEAR_BIT];
  assign start_cmd = wr && (S_address == ADDR_CMD) && S_din[CMD_START_BIT] && !S_din[CMD_CLEAR_BIT];
  assign push_a    = wr && (S_address == ADDR_OPA);
  assign push_b    = wr && (S_address == ADDR_OPB);

  mult_slave_cnt #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .reset_n(reset_n), .clear(clear_cmd), .push(push_a),
    .allow(state_q == ST_IDLE), .accept(acc_a), .cnt(cnt_a), .ovf(ovf_a)
  );

  mult_slave_cnt #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .reset_n(reset_n), .clear(clear_cmd), .push(push_b),
    .allow(state_q == ST_IDLE), .accept(acc_b), .cnt(cnt_b), .ovf(ovf_b)
  );

  assign full = (cnt_a == CNT_W'(DEPTH)) && (cnt_b == CNT_W'(DEPTH));

`ifdef MULT_SLAVE_TMO_EN
  localparam int unsigned WD_W = $clog2(TMO_CYC + 1);
  logic [WD_W-1:0] wdog_q;
  logic busy;

  assign busy    = (state_q == ST_MULT) || (state_q == ST_ADD);
  assign tmo_hit = busy && (wdog_q == WD_W'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else if (!busy || (state_d != state_q)) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + WD_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Event decode: a completion arriving on the watchdog's last cycle still counts
  always_comb begin
    multi_go = 1'b0;
    adder_go = 1'b0;
    done_set = 1'b0;
    serr_set = 1'b0;
    tmo_set  = 1'b0;
    if (!clear_cmd) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_cmd) begin
            if (full) multi_go = 1'b1;
            else      serr_set = 1'b1;
          end
        end
        ST_MULT: begin
          if (multi_opdone) adder_go = 1'b1;
          else if (tmo_hit) tmo_set  = 1'b1;
        end
        ST_ADD: begin
          if (adder_opdone) done_set = 1'b1;
          else if (tmo_hit) tmo_set  = 1'b1;
        end
        ST_DONE: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_cmd)     state_d = ST_IDLE;
    else if (multi_go) state_d = ST_MULT;
    else if (adder_go) state_d = ST_ADD;
    else if (done_set) state_d = ST_DONE;
    else if (tmo_set)  state_d = ST_IDLE;
  end

  always_comb begin
    w1c_mask = '0;
    if (wr && (S_address == ADDR_INT_PEND)) w1c_mask = S_din[1:0];
    set_mask = '0;
    set_mask[INT_DONE_BIT] = done_set;
    set_mask[INT_ERR_BIT]  = serr_set | tmo_set;
  end

  always_comb begin
    status = '0;
    status[1:0]           = state_q;
    status[STAT_OVF_BIT]  = ovf_a | ovf_b;
    status[STAT_SERR_BIT] = start_err_q;
    status[STAT_TMO_BIT]  = timeout_q;
    status[STAT_CNTA_LSB +: 8] = 8'(cnt_a);
    status[STAT_CNTB_LSB +: 8] = 8'(cnt_b);
  end

  always_comb begin
    rd_data = '0;
    case (S_address)
      ADDR_INT_EN:   rd_data[1:0] = int_en_q;
      ADDR_STATUS:   rd_data = status;
      ADDR_INT_PEND: rd_data[1:0] = int_pend_q;
      ADDR_RADDR:    rd_data[RADDR_W-1:0] = rAddr;
      ADDR_RESULT:   rd_data = result;
      default:       ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      multi_opstart   <= 1'b0;
      adder_opstart   <= 1'b0;
      multi_opclear   <= 1'b0;
      start_err_q     <= 1'b0;
      timeout_q       <= 1'b0;
      int_pend_q      <= '0;
      int_en_q        <= '0;
      rAddr           <= '0;
      S_dout          <= '0;
      multiplicand    <= '0;
      multiplicand_we <= 1'b0;
      multiplier      <= '0;
      multiplier_we   <= 1'b0;
    end else begin
      multi_opstart   <= multi_go;
      adder_opstart   <= adder_go;
      multi_opclear   <= clear_cmd;
      start_err_q     <= clear_cmd ? 1'b0 : (start_err_q | serr_set);
      timeout_q       <= clear_cmd ? 1'b0 : (timeout_q | tmo_set);
      int_pend_q      <= (int_pend_q & ~w1c_mask) | set_mask;
      if (wr && (S_address == ADDR_INT_EN)) int_en_q <= S_din[1:0];
      if (wr && (S_address == ADDR_RADDR))  rAddr    <= S_din[RADDR_W-1:0];
      if (rd) S_dout <= rd_data;
      multiplicand_we <= acc_a;
      multiplier_we   <= acc_b;
      if (acc_a) multiplicand <= S_din;
      if (acc_b) multiplier   <= S_din;
    end
  end

  assign m_interrupt = |(int_pend_q & int_en_q);

endmodule

// File: tb/tb_mult_slave_ctrl.sv
// Self-checking bench for mult_slave_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a register-level model.
module tb_mult_slave_ctrl;

  localparam int unsigned TMO = 16;
`ifdef MULT_SLAVE_TMO_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  localparam logic [3:0] A_OPA = 4'd0, A_OPB = 4'd1, A_EN = 4'd2, A_CMD = 4'd3,
                         A_STAT = 4'd4, A_PEND = 4'd5, A_RADDR = 4'd6, A_RES = 4'd7;

  // flag order: {we_a, we_b, mstart, astart, clear, irq}
  localparam logic [5:0] F_WA = 6'b100000, F_WB = 6'b010000, F_MS = 6'b001000,
                         F_AS = 6'b000100, F_CL = 6'b000010, F_IRQ = 6'b000001;

  logic        clk, reset_n, S_sel, S_wr, multi_opdone, adder_opdone;
  logic [3:0]  S_address, rAddr;
  logic [31:0] S_din, S_dout, multiplicand, multiplier, result;
  logic        multiplicand_we, multiplier_we, multi_opstart, adder_opstart, multi_opclear, m_interrupt;

  logic [31:0] mem [16];
  assign result = mem[rAddr];

  mult_slave_ctrl #(.DATA_W(32), .DEPTH(8), .RADDR_W(4), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .S_sel(S_sel), .S_wr(S_wr), .S_address(S_address),
    .S_din(S_din), .S_dout(S_dout), .multiplicand(multiplicand), .multiplicand_we(multiplicand_we),
    .multiplier(multiplier), .multiplier_we(multiplier_we), .multi_opstart(multi_opstart),
    .multi_opdone(multi_opdone), .adder_opstart(adder_opstart), .adder_opdone(adder_opdone),
    .multi_opclear(multi_opclear), .rAddr(rAddr), .result(result), .m_interrupt(m_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [5:0] flags_now();
    return {multiplicand_we, multiplier_we, multi_opstart, adder_opstart, multi_opclear, m_interrupt};
  endfunction

  // One bus cycle: drive at a falling edge, return at the next falling edge.
  task automatic do_cycle(input bit sel, input bit wr, input logic [3:0] a, input logic [31:0] d,
                          input bit md, input bit ad);
    S_sel = sel; S_wr = wr; S_address = a; S_din = d; multi_opdone = md; adder_opdone = ad;
    @(negedge clk);
    S_sel = 1'b0; S_wr = 1'b0; S_address = '0; S_din = '0; multi_opdone = 1'b0; adder_opdone = 1'b0;
  endtask

  task automatic bw(input logic [3:0] a, input logic [31:0] d);
    do_cycle(1'b1, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic br(input logic [3:0] a);
    do_cycle(1'b1, 1'b0, a, '0, 1'b0, 1'b0);
  endtask

  task automatic fill_operands();
    for (int i = 0; i < 8; i++) begin
      bw(A_OPA, 32'h10 + 32'(i));
      bw(A_OPB, 32'h20 + 32'(i));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          sel, wr, md, ad, chk;
    logic [3:0]  addr;
    logic [31:0] din, dout;
    logic [5:0]  flags;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit sel, input bit wr, input logic [3:0] a, input logic [31:0] d,
                     input bit md, input bit ad, input bit chk, input logic [31:0] dout,
                     input logic [5:0] f);
    vec_t v;
    v.sel = sel; v.wr = wr; v.addr = a; v.din = d; v.md = md; v.ad = ad;
    v.chk = chk; v.dout = dout; v.flags = f;
    tbl.push_back(v);
  endtask

  task automatic build_table();
    for (int i = 0; i < 8; i++) add(1, 1, A_OPA, 32'hA000 + 32'(i), 0, 0, 0, 0, F_WA);
    for (int i = 0; i < 8; i++) add(1, 1, A_OPB, 32'hB000 + 32'(i), 0, 0, 0, 0, F_WB);
    add(1, 1, A_OPA, 32'h999, 0, 0, 0, 0, 6'b0);                 // 9th push dropped
    add(1, 0, A_STAT, 0, 0, 0, 1, 32'h0008_0804, 6'b0);
    add(1, 1, A_EN, 32'h1, 0, 0, 0, 0, 6'b0);
    add(1, 1, A_CMD, 32'h1, 0, 0, 0, 0, F_MS);
    add(1, 0, A_STAT, 0, 0, 0, 1, 32'h0008_0805, 6'b0);
    add(0, 0, 4'd0, 0, 0, 1, 0, 0, 6'b0);                        // add done in MULT ignored
    add(0, 0, 4'd0, 0, 1, 0, 0, 0, F_AS);
    add(1, 0, A_STAT, 0, 0, 0, 1, 32'h0008_0806, 6'b0);
    add(0, 0, 4'd0, 0, 0, 1, 0, 0, F_IRQ);
    add(1, 0, A_STAT, 0, 0, 0, 1, 32'h0008_0807, F_IRQ);
    add(1, 0, A_PEND, 0, 0, 0, 1, 32'h1, F_IRQ);
    add(1, 1, A_CMD, 32'h1, 0, 0, 0, 0, F_IRQ);                  // START in DONE ignored
    add(1, 1, A_PEND, 32'h1, 0, 0, 0, 0, 6'b0);
    add(1, 1, A_RADDR, 32'h5, 0, 0, 0, 0, 6'b0);
    add(1, 0, A_RADDR, 0, 0, 0, 1, 32'h5, 6'b0);
    add(1, 0, A_RES, 0, 0, 0, 1, 32'hDEAD_BEEF, 6'b0);
    add(1, 0, 4'd12, 0, 0, 0, 1, 32'h0, 6'b0);
    add(1, 1, A_CMD, 32'h2, 0, 0, 0, 0, F_CL);
    add(1, 0, A_STAT, 0, 0, 0, 1, 32'h0, 6'b0);
    for (int i = 0; i < 3; i++) add(1, 1, A_OPA, 32'hC0 + 32'(i), 0, 0, 0, 0, F_WA);
    add(1, 1, A_EN, 32'h3, 0, 0, 0, 0, 6'b0);
    add(1, 1, A_CMD, 32'h1, 0, 0, 0, 0, F_IRQ);                  // START short of operands
    add(1, 0, A_STAT, 0, 0, 0, 1, 32'h0000_0308, F_IRQ);
    add(1, 0, A_PEND, 0, 0, 0, 1, 32'h2, F_IRQ);
    add(1, 1, A_PEND, 32'h2, 0, 0, 0, 0, 6'b0);
    add(1, 1, A_CMD, 32'h2, 0, 0, 0, 0, F_CL);
  endtask

  // ---------------- reference model ----------------
  int          m_state, m_ca, m_cb, m_dwell, m_raddr;
  bit          m_ovf, m_serr, m_tmo;
  logic [1:0]  m_en, m_pend;
  logic [31:0] m_dout, m_opa, m_opb;
  bit          e_wa, e_wb, e_ms, e_as, e_clr;

  task automatic model_reset();
    m_state = 0; m_ca = 0; m_cb = 0; m_dwell = 0; m_raddr = 0;
    m_ovf = 0; m_serr = 0; m_tmo = 0; m_en = 0; m_pend = 0;
    m_dout = 0; m_opa = 0; m_opb = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      A_EN:    return {30'b0, m_en};
      A_STAT:  return 32'(m_state) + 32'(m_ovf) * 4 + 32'(m_serr) * 8 + 32'(m_tmo) * 16
                      + 32'(m_ca) * 256 + 32'(m_cb) * 65536;
      A_PEND:  return {30'b0, m_pend};
      A_RADDR: return 32'(m_raddr);
      A_RES:   return mem[m_raddr];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input bit sel, input bit wr, input logic [3:0] a, input logic [31:0] d,
                            input bit md, input bit ad);
    bit w, clr, start;
    logic [1:0] set;
    int nxt;
    w = sel && wr;
    clr = w && a == A_CMD && d[1];
    start = w && a == A_CMD && d[0] && !clr;
    set = 2'b00; nxt = m_state;
    e_wa = 0; e_wb = 0; e_ms = 0; e_as = 0; e_clr = 0;
    if (sel && !wr) m_dout = model_read(a);
    if (w && a == A_OPA) begin
      if (m_state == 0 && m_ca < 8) begin m_ca++; m_opa = d; e_wa = 1; end
      else m_ovf = 1;
    end
    if (w && a == A_OPB) begin
      if (m_state == 0 && m_cb < 8) begin m_cb++; m_opb = d; e_wb = 1; end
      else m_ovf = 1;
    end
    if (w && a == A_EN)    m_en = d[1:0];
    if (w && a == A_RADDR) m_raddr = int'(d[3:0]);
    if (clr) begin
      e_clr = 1; m_ca = 0; m_cb = 0; m_ovf = 0; m_serr = 0; m_tmo = 0; nxt = 0;
    end else if (m_state == 0 && start) begin
      if (m_ca == 8 && m_cb == 8) begin e_ms = 1; nxt = 1; end
      else begin m_serr = 1; set[1] = 1; end
    end else if (m_state == 1 || m_state == 2) begin
      if (m_state == 1 && md) begin e_as = 1; nxt = 2; end
      else if (m_state == 2 && ad) begin set[0] = 1; nxt = 3; end
      else if (TMO_ON && m_dwell == TMO - 1) begin m_tmo = 1; set[1] = 1; nxt = 0; end
    end
    if (w && a == A_PEND) m_pend = m_pend & ~d[1:0];
    m_pend = m_pend | set;
    m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
    m_state = nxt;
  endtask

  task automatic random_run(input int cycles);
    int r;
    bit sel, wr, md, ad;
    logic [3:0] a;
    logic [31:0] d;
    for (int c = 0; c < cycles; c++) begin
      r = int'($urandom_range(0, 199));
      sel = 1; wr = 1; a = A_OPA; d = $urandom;
      if (r < 45)       a = A_OPA;
      else if (r < 90)  a = A_OPB;
      else if (r < 110) begin a = A_CMD; d = 32'h1; end
      else if (r < 112) begin a = A_CMD; d = 32'h2; end
      else if (r < 114) begin a = A_CMD; d = 32'h3; end
      else if (r < 122) a = A_EN;
      else if (r < 132) a = A_PEND;
      else if (r < 138) a = A_RADDR;
      else if (r < 142) a = 4'(8 + $urandom_range(0, 7));
      else if (r < 175) begin wr = 0; a = 4'($urandom_range(0, 15)); end
      else begin sel = 0; wr = 0; end
      md = ($urandom_range(0, 99) < 15);
      ad = ($urandom_range(0, 99) < 15);
      model_step(sel, wr, a, d, md, ad);
      do_cycle(sel, wr, a, d, md, ad);
      check($sformatf("rnd%0d flags", c), {26'b0, flags_now()},
            {26'b0, e_wa, e_wb, e_ms, e_as, e_clr, |(m_pend & m_en)});
      check($sformatf("rnd%0d dout", c), S_dout, m_dout);
      check($sformatf("rnd%0d raddr", c), {28'b0, rAddr}, 32'(m_raddr));
      if (e_wa) check($sformatf("rnd%0d opa", c), multiplicand, m_opa);
      if (e_wb) check($sformatf("rnd%0d opb", c), multiplier, m_opb);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[5] = 32'hDEAD_BEEF;
    reset_n = 1'b0; S_sel = 0; S_wr = 0; S_address = '0; S_din = '0;
    multi_opdone = 0; adder_opdone = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    check("reset flags", {26'b0, flags_now()}, 32'h0);
    check("reset dout", S_dout, 32'h0);
    br(A_STAT);
    check("reset status", S_dout, 32'h0);
    check("reset irq", {31'b0, m_interrupt}, 32'h0);

    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      do_cycle(tbl[i].sel, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].md, tbl[i].ad);
      check($sformatf("vec%0d flags", i), {26'b0, flags_now()}, {26'b0, tbl[i].flags});
      if (tbl[i].chk) check($sformatf("vec%0d dout", i), S_dout, tbl[i].dout);
    end

    // Withheld multiply completion: watchdog abort, or indefinite wait without it
    fill_operands();
    bw(A_CMD, 32'h1);
    check("tmo start", {26'b0, flags_now()}, {26'b0, F_MS});
    repeat (15) @(negedge clk);
    br(A_STAT);
    check("tmo last mult cycle", S_dout, 32'h0008_0801);
    br(A_STAT);
    check("tmo status", S_dout, TMO_ON ? 32'h0008_0810 : 32'h0008_0801);
    check("tmo irq", {31'b0, m_interrupt}, {31'b0, TMO_ON});
    bw(A_CMD, 32'h3);
    check("clear+start", {26'b0, flags_now()}, {26'b0, F_CL | (TMO_ON ? F_IRQ : 6'b0)});
    br(A_STAT);
    check("clear+start status", S_dout, 32'h0);
    bw(A_PEND, 32'h3);

    // W1C of the done bit in the same cycle the done bit is set
    fill_operands();
    bw(A_CMD, 32'h1);
    do_cycle(0, 0, 4'd0, 0, 1, 0);
    check("w1c seq astart", {26'b0, flags_now()}, {26'b0, F_AS});
    do_cycle(1, 1, A_PEND, 32'h1, 0, 1);
    check("w1c vs set irq", {26'b0, flags_now()}, {26'b0, F_IRQ});
    br(A_PEND);
    check("w1c vs set pend", S_dout, 32'h1);

    // Asynchronous reset in the middle of a cycle
    #2 reset_n = 1'b0;
    #1;
    check("async reset flags", {26'b0, flags_now()}, 32'h0);
    check("async reset dout", S_dout, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    br(A_STAT);
    check("post reset status", S_dout, 32'h0);

    model_reset();
    random_run(1500);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
